// File: rtl/div_pkg.sv
// Shared types for the divider issue stage: FSM states, operand and result records.
package div_pkg;

    localparam int DIV_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        GUARD,
        WAIT,
        HOLD
    } div_state_e;

    typedef struct packed {
        logic [DIV_W-1:0] dividend;
        logic [DIV_W-1:0] divisor;
    } div_op_t;

    typedef struct packed {
        logic [DIV_W-1:0] quotient;
        logic [DIV_W-1:0] remainder;
        logic             div0;
    } div_res_t;

endpackage

// File: rtl/div_op_fifo.sv
// Operand FIFO for the divider issue stage: DEPTH entries of div_op_t, head visible combinationally.
// Full never bypasses; a push and a pop in the same cycle leave the count unchanged.
module div_op_fifo
    import div_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  logic    pop,
    input  div_op_t push_op,
    output div_op_t head_op,
    output logic    full,
    output logic    empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    div_op_t         mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head_op = mem[rd_ptr];

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_op;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue stage for the 16-bit sequential divider: buffers operands, runs one divide at a time,
// holds the result for the consumer. Optional macro DIV_ZERO_BYPASS_EN answers zero divisors locally.
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic             div_start,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic             div_ready,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             out_div0
);

    div_state_e state;
    div_state_e state_next;
    div_op_t    push_op;
    div_op_t    head_op;
    div_op_t    op_q;
    div_res_t   res_q;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    logic       load_op;
    logic       load_zero;
    logic       capture;
    logic       zero_head;

    assign push_op.dividend = in_dividend;
    assign push_op.divisor  = in_divisor;
    assign in_ready         = !fifo_full;

    div_op_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (in_valid && in_ready),
        .pop    (fifo_pop),
        .push_op(push_op),
        .head_op(head_op),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

`ifdef DIV_ZERO_BYPASS_EN
    assign zero_head = (head_op.divisor == '0);
`else
    assign zero_head = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // GUARD exists because the divider's ready is stale during the start cycle.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        load_op    = 1'b0;
        load_zero  = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && zero_head) begin
                    fifo_pop   = 1'b1;
                    load_zero  = 1'b1;
                    state_next = HOLD;
                end else if (!fifo_empty && div_ready) begin
                    fifo_pop   = 1'b1;
                    load_op    = 1'b1;
                    state_next = GUARD;
                end
            end
            GUARD: state_next = WAIT;
            WAIT: begin
                if (div_ready) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands stay put from issue until the next issue, covering the whole divide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q <= '0;
        end else if (load_op) begin
            op_q <= head_op;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_q <= '0;
        end else if (capture) begin
            res_q.quotient  <= div_quotient;
            res_q.remainder <= div_remainder;
            res_q.div0      <= 1'b0;
        end else if (load_zero) begin
            res_q.quotient  <= '1;
            res_q.remainder <= head_op.dividend;
            res_q.div0      <= 1'b1;
        end
    end

    assign div_start     = (state == GUARD);
    assign div_dividend  = op_q.dividend;
    assign div_divisor   = op_q.divisor;
    assign out_valid     = (state == HOLD);
    assign out_quotient  = res_q.quotient;
    assign out_remainder = res_q.remainder;
    assign out_div0      = res_q.div0;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Randomized bench for div_issue_ctrl: behavioural divider, scoreboard of expected results.
module tb_div_issue_ctrl;

    localparam int W     = 16;
    localparam int DEPTH = 4;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         div0;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_dividend;
    logic [W-1:0] in_divisor;
    logic         div_start;
    logic [W-1:0] div_dividend;
    logic [W-1:0] div_divisor;
    logic         div_ready;
    logic [W-1:0] div_quotient;
    logic [W-1:0] div_remainder;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_quotient;
    logic [W-1:0] out_remainder;
    logic         out_div0;

    int   num_checks = 0;
    int   num_pass   = 0;
    int   starts     = 0;
    int   div_lat    = 17;
    int   ready_mode = 0;
    int   n_pushed   = 0;
    int   n_results  = 0;
    exp_t sb[$];

`ifdef DIV_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    always #5 clk = ~clk;

    div_issue_ctrl #(
        .WIDTH(W),
        .DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dividend  (in_dividend),
        .in_divisor   (in_divisor),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_ready    (div_ready),
        .div_quotient (div_quotient),
        .div_remainder(div_remainder),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_quotient (out_quotient),
        .out_remainder(out_remainder),
        .out_div0     (out_div0)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual === expected) begin
            num_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == 0) begin
            e.q    = 16'hFFFF;
            e.r    = a;
            e.div0 = BYPASS;
        end else begin
            e.q    = a / b;
            e.r    = a % b;
            e.div0 = 1'b0;
        end
        return e;
    endfunction

    // Sequential divider stand-in: ready drops after start, result appears div_lat cycles later.
    initial begin
        int busy_cnt;
        logic [W-1:0] m_a;
        logic [W-1:0] m_b;
        busy_cnt = 0;
        m_a = '0;
        m_b = '0;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                div_ready     <= 1'b1;
                div_quotient  <= '0;
                div_remainder <= '0;
                busy_cnt = 0;
            end else if (busy_cnt > 0) begin
                if (div_start) begin
                    checkOutput("start_while_busy", 32'd1, 32'd0);
                end
                busy_cnt--;
                if (busy_cnt == 0) begin
                    div_ready     <= 1'b1;
                    div_quotient  <= (m_b == 0) ? 16'hFFFF : m_a / m_b;
                    div_remainder <= (m_b == 0) ? m_a : m_a % m_b;
                end
            end else if (div_start) begin
                starts++;
                m_a = div_dividend;
                m_b = div_divisor;
                busy_cnt = (div_lat < 1) ? 1 : div_lat;
                div_ready <= 1'b0;
            end
        end
    end

    // Consumer: drives out_ready per mode and scores every accepted result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0: out_ready = 1'b0;
                1: out_ready = 1'b1;
                2: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    out_ready  = 1'b1;
                    ready_mode = 0;
                end
            endcase
            if (rst && out_valid && out_ready) begin
                n_results++;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("quotient", out_quotient, e.q);
                    checkOutput("remainder", out_remainder, e.r);
                    checkOutput("div0", out_div0, e.div0);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        int waited;
        waited = 0;
        @(negedge clk);
        in_valid    = 1'b1;
        in_dividend = a;
        in_divisor  = b;
        while (!in_ready && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checkOutput("push_timeout", in_ready, 32'd1);
            in_valid = 1'b0;
        end else begin
            sb.push_back(model(a, b));
            n_pushed++;
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while ((sb.size() != 0 || out_valid) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("drain", sb.size(), 32'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_in_ready"}, in_ready, 32'd1);
        checkOutput({tag, "_div_start"}, div_start, 32'd0);
        checkOutput({tag, "_out_valid"}, out_valid, 32'd0);
        checkOutput({tag, "_div_dividend"}, div_dividend, 32'd0);
        checkOutput({tag, "_div_divisor"}, div_divisor, 32'd0);
        checkOutput({tag, "_out_quotient"}, out_quotient, 32'd0);
        checkOutput({tag, "_out_remainder"}, out_remainder, 32'd0);
        checkOutput({tag, "_out_div0"}, out_div0, 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s0;
        int cyc;
        int seen;
        logic [W-1:0] a;
        logic [W-1:0] b;

        in_valid    = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        out_ready   = 1'b0;

        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b1;

        $display("[TB] single operation 100/7");
        ready_mode = 1;
        div_lat    = 17;
        s0         = starts;
        applyStimulus(16'd100, 16'd7);
        cyc = 0;
        while (div_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        cyc = 0;
        while (!div_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("t1_valid_before_capture", out_valid, 32'd0);
        @(negedge clk);
        checkOutput("t1_valid_after_capture", out_valid, 32'd1);
        drain();
        checkOutput("t1_start_pulses", starts - s0, 32'd1);

        $display("[TB] back-pressure and push/pop around full");
        ready_mode = 0;
        div_lat    = $urandom_range(3, 10);
        s0         = starts;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(16'($urandom), 16'($urandom_range(1, 300)));
        end
        repeat (40) @(negedge clk);
        checkOutput("t2_fifo_full", in_ready, 32'd0);
        checkOutput("t2_result_held", out_valid, 32'd1);
        ready_mode = 3;
        applyStimulus(16'($urandom), 16'($urandom_range(1, 300)));
        @(negedge clk);
        checkOutput("t3_full_again", in_ready, 32'd0);
        ready_mode = 1;
        drain();
        checkOutput("t2_start_pulses", starts - s0, 32'd6);

        $display("[TB] reset during WAIT");
        div_lat = 17;
        s0      = starts;
        applyStimulus(16'd200, 16'd3);
        cyc = 0;
        while (starts == s0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checkResetOutputs("midop");
        n_pushed -= sb.size();
        sb.delete();
        repeat (2) @(negedge clk);
        rst  = 1'b1;
        s0   = starts;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        checkOutput("t4_stale_valid", seen, 32'd0);
        checkOutput("t4_stale_start", starts - s0, 32'd0);

        $display("[TB] divide by zero 55/0");
        div_lat = 5;
        s0      = starts;
        applyStimulus(16'd55, 16'd0);
        drain();
        checkOutput("t5_start_pulses", starts - s0, BYPASS ? 32'd0 : 32'd1);

        $display("[TB] random wrap-around stream");
        ready_mode = 2;
        for (int i = 0; i < 10; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0: b = '0;
                1: b = 16'($urandom_range(1, 15));
                default: b = 16'($urandom);
            endcase
            div_lat = $urandom_range(1, 20);
            applyStimulus(a, b);
        end
        ready_mode = 1;
        drain();
        checkOutput("result_count", n_results, n_pushed);

        $display("%0d/%0d checks passed", num_pass, num_checks);
        $finish;
    end

endmodule
